// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths, FSM state encoding and scoreboard entry type
//               for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_AW = 6;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

    function automatic logic sb_match(input sb_entry_t e, input logic [REG_AW-1:0] r);
        return e.v && (e.rd == r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : RAW-stall and redirect-squash sequencer for the 5-stage pipe,
//               with a 3-entry in-flight write scoreboard and event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              mem_redirect,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              hazard,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t    r_state;
    sb_entry_t r_sb_ex;
    sb_entry_t r_sb_mem;
    sb_entry_t r_sb_wb;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_redirect;
    logic w_stall;

    // WB is included: the register file does not bypass a same-cycle write.
    assign w_rs_hit = sb_match(r_sb_ex, id_rs) || sb_match(r_sb_mem, id_rs) || sb_match(r_sb_wb, id_rs);
    assign w_rt_hit = sb_match(r_sb_ex, id_rt) || sb_match(r_sb_mem, id_rt) || sb_match(r_sb_wb, id_rt);
    assign hazard   = id_valid && ((id_uses_rs && w_rs_hit) || (id_uses_rt && w_rt_hit));

    // Masked by rst_n so the pipeline sees plain run-mode controls while held in reset.
    assign w_redirect = mem_redirect && rst_n;
    assign w_stall    = !w_redirect && (r_state != SQUASH) && hazard;

    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        if (w_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (r_state == SQUASH) begin
            ifid_flush  = 1'b1;
        end else if (w_stall) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_flush    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_sb_ex  <= '0;
            r_sb_mem <= '0;
            r_sb_wb  <= '0;
        end else if (w_redirect) begin
            r_state  <= SQUASH;
            r_sb_ex  <= '0;
            r_sb_mem <= '0;
            r_sb_wb  <= r_sb_mem;
        end else if (w_stall) begin
            r_state  <= STALL;
            r_sb_ex  <= '0;
            r_sb_mem <= r_sb_ex;
            r_sb_wb  <= r_sb_mem;
        end else begin
            r_state  <= RUN;
            r_sb_ex  <= '{v: id_valid && id_reg_write, rd: id_rd};
            r_sb_mem <= r_sb_ex;
            r_sb_wb  <= r_sb_mem;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_stall),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_redirect),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed-vector scoreboard bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    // Control vector order: {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, hazard}
    localparam logic [5:0] C_NORM = 6'b110000;
    localparam logic [5:0] C_STAL = 6'b000101;
    localparam logic [5:0] C_REDR = 6'b111110;
    localparam logic [5:0] C_REDH = 6'b111111;
    localparam logic [5:0] C_SQSH = 6'b111000;

    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [5:0]  id_rs = '0;
    logic [5:0]  id_rt = '0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic [5:0]  id_rd = '0;
    logic        id_reg_write = 1'b0;
    logic        mem_redirect = 1'b0;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        hazard;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipe_hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .mem_redirect  (mem_redirect),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .hazard        (hazard),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                          input logic urs, input logic urt, input logic [5:0] rd,
                          input logic rw, input logic redir);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_rd        = rd;
        id_reg_write = rw;
        mem_redirect = redir;
    endtask

    // One cycle: drive just after the rising edge, queue the response expected at the falling edge.
    task automatic apply(input string nm, input logic rn,
                         input logic v, input logic [5:0] rs, input logic [5:0] rt,
                         input logic urs, input logic urt, input logic [5:0] rd,
                         input logic rw, input logic redir,
                         input logic [5:0] ctl, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn;
        set_in(v, rs, rt, urs, urt, rd, rw, redir);
        e.name = nm;
        e.ctl  = ctl;
        e.sc   = sc;
        e.fc   = fc;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {pc_write_en, ifid_write_en, ifid_flush, idex_flush, exmem_flush, hazard};
                n_vec++;
                if (act !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_err++;
                    $display("FAIL %s: got ctl=%b stall_cnt=%0d flush_cnt=%0d, want ctl=%b stall_cnt=%0d flush_cnt=%0d",
                             e.name, act, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : stim
        //     name          rn v  rs    rt    urs  urt  rd    rw  rdr  ctl     sc  fc
        apply("reset",       0, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_NORM, 0,  0);
        apply("post_reset",  1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_NORM, 0,  0);
        // Back-to-back RAW on r5: three stalls.
        apply("prod_r5",     1, 1, 6'd0, 6'd0, 0,   0,   6'd5, 1,  0,   C_NORM, 0,  0);
        apply("raw1_st1",    1, 1, 6'd5, 6'd0, 1,   0,   6'd6, 0,  0,   C_STAL, 0,  0);
        apply("raw1_st2",    1, 1, 6'd5, 6'd0, 1,   0,   6'd6, 0,  0,   C_STAL, 1,  0);
        apply("raw1_st3",    1, 1, 6'd5, 6'd0, 1,   0,   6'd6, 0,  0,   C_STAL, 2,  0);
        apply("raw1_go",     1, 1, 6'd5, 6'd0, 1,   0,   6'd6, 0,  0,   C_NORM, 3,  0);
        // Producer three ahead on rt: one stall; then rt unused: none.
        apply("prod_r7",     1, 1, 6'd0, 6'd0, 0,   0,   6'd7, 1,  0,   C_NORM, 3,  0);
        apply("indep_a",     1, 1, 6'd0, 6'd0, 0,   0,   6'd1, 0,  0,   C_NORM, 3,  0);
        apply("indep_b",     1, 1, 6'd0, 6'd0, 0,   0,   6'd1, 0,  0,   C_NORM, 3,  0);
        apply("raw3_st",     1, 1, 6'd0, 6'd7, 0,   1,   6'd2, 0,  0,   C_STAL, 3,  0);
        apply("raw3_go",     1, 1, 6'd0, 6'd7, 0,   1,   6'd2, 0,  0,   C_NORM, 4,  0);
        apply("prod_r7b",    1, 1, 6'd0, 6'd0, 0,   0,   6'd7, 1,  0,   C_NORM, 4,  0);
        apply("indep_c",     1, 1, 6'd0, 6'd0, 0,   0,   6'd1, 0,  0,   C_NORM, 4,  0);
        apply("indep_d",     1, 1, 6'd0, 6'd0, 0,   0,   6'd1, 0,  0,   C_NORM, 4,  0);
        apply("rt_unused",   1, 1, 6'd0, 6'd7, 0,   0,   6'd2, 0,  0,   C_NORM, 4,  0);
        // Redirect squashes the pending r9 write.
        apply("prod_r9",     1, 1, 6'd0, 6'd0, 0,   0,   6'd9, 1,  0,   C_NORM, 4,  0);
        apply("redirect",    1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  1,   C_REDR, 4,  0);
        apply("squash",      1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_SQSH, 4,  1);
        apply("r9_cleared",  1, 1, 6'd9, 6'd0, 1,   0,   6'd0, 0,  0,   C_NORM, 4,  1);
        // Redirect arriving mid-stall cancels it.
        apply("prod_r3",     1, 1, 6'd0, 6'd0, 0,   0,   6'd3, 1,  0,   C_NORM, 4,  1);
        apply("raw_r3_st",   1, 1, 6'd3, 6'd0, 1,   0,   6'd0, 0,  0,   C_STAL, 4,  1);
        apply("redir_stall", 1, 1, 6'd3, 6'd0, 1,   0,   6'd0, 0,  1,   C_REDH, 5,  1);
        apply("squash2",     1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_SQSH, 5,  2);
        apply("run_again",   1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_NORM, 5,  2);

        // Self-dependent stream: 3 stalls per 4 cycles, far past the counter limit.
        @(posedge clk);
        #1;
        set_in(1, 6'd1, 6'd0, 1, 0, 6'd1, 1, 0);
        repeat (88000) @(posedge clk);
        #1;
        set_in(0, 6'd0, 6'd0, 0, 0, 6'd0, 0, 0);
        repeat (4) @(posedge clk);

        apply("sat_hold",    1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_NORM, 16'hFFFF, 2);
        apply("prod_r2",     1, 1, 6'd0, 6'd0, 0,   0,   6'd2, 1,  0,   C_NORM, 16'hFFFF, 2);
        apply("sat_stall",   1, 1, 6'd2, 6'd0, 1,   0,   6'd0, 0,  0,   C_STAL, 16'hFFFF, 2);
        // Reset lands mid-stall, between edges.
        apply("rst_mid",     0, 1, 6'd2, 6'd0, 1,   0,   6'd0, 0,  0,   C_NORM, 0,  0);
        apply("rst_release", 1, 0, 6'd0, 6'd0, 0,   0,   6'd0, 0,  0,   C_NORM, 0,  0);
        apply("rst_clear",   1, 1, 6'd2, 6'd0, 1,   0,   6'd0, 0,  0,   C_NORM, 0,  0);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
